// File: rtl/conv_row_sequencer.sv
// conv_row_sequencer
// Streams image rows from the source row memory through the 128-lane 3-tap
// convolution array and writes each result row to the destination memory.
// Each row is read, padded to a 130-byte window, held on the array for its
// fixed latency, and then written back with wr_ready backpressure.

module conv_row_sequencer #(
  parameter int CONV_LAT = 2,
  parameter int ADDR_W   = 10,
  parameter int ROW_W    = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ROW_W-1:0]  num_rows,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [23:0]       weight_in,
  input  logic              pad_mode,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [1023:0]     rd_data,
  output logic [1039:0]     conv_data,
  output logic [23:0]       conv_weight,
  input  logic [1023:0]     conv_result,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [1023:0]     wr_data,
  input  logic              wr_ready
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  // The wait counter only has to hold CONV_LAT-1.
  localparam int CNT_W = (CONV_LAT > 1) ? $clog2(CONV_LAT) : 1;

  logic [2:0]        state_q,    state_d;
  logic [ROW_W-1:0]  row_q,      row_d;
  logic [ROW_W-1:0]  numRows_q,  numRows_d;
  logic [ADDR_W-1:0] srcBase_q,  srcBase_d;
  logic [ADDR_W-1:0] dstBase_q,  dstBase_d;
  logic [23:0]       weight_q,   weight_d;
  logic              padMode_q,  padMode_d;
  logic [1039:0]     convData_q, convData_d;
  logic [CNT_W-1:0]  waitCnt_q,  waitCnt_d;

  logic [7:0]        leftPad;
  logic [7:0]        rightPad;
  logic [1039:0]     window;

  // Build the padded window from the row currently arriving on rd_data.
  always_comb begin
    leftPad  = padMode_q ? rd_data[7:0]       : 8'h00;
    rightPad = padMode_q ? rd_data[1023:1016] : 8'h00;
    window   = {rightPad, rd_data, leftPad};
  end

  // Row FSM: next state, configuration capture, window load and counters.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    numRows_d  = numRows_q;
    srcBase_d  = srcBase_q;
    dstBase_d  = dstBase_q;
    weight_d   = weight_q;
    padMode_d  = padMode_q;
    convData_d = convData_q;
    waitCnt_d  = waitCnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          numRows_d = num_rows;
          srcBase_d = src_base;
          dstBase_d = dst_base;
          weight_d  = weight_in;
          padMode_d = pad_mode;
          row_d     = '0;
          state_d   = (num_rows == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        convData_d = window;
        waitCnt_d  = CNT_W'(CONV_LAT - 1);
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (waitCnt_q == '0) begin
          state_d = S_WRITE;
        end else begin
          waitCnt_d = waitCnt_q - CNT_W'(1);
        end
      end
      S_WRITE: begin
        if (wr_ready) begin
          row_d   = row_q + ROW_W'(1);
          state_d = ((row_q + ROW_W'(1)) == numRows_q) ? S_DONE : S_READ;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any job in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      numRows_q  <= '0;
      srcBase_q  <= '0;
      dstBase_q  <= '0;
      weight_q   <= '0;
      padMode_q  <= 1'b0;
      convData_q <= '0;
      waitCnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      numRows_q  <= numRows_d;
      srcBase_q  <= srcBase_d;
      dstBase_q  <= dstBase_d;
      weight_q   <= weight_d;
      padMode_q  <= padMode_d;
      convData_q <= convData_d;
      waitCnt_q  <= waitCnt_d;
    end
  end

  // Outputs decode the registered state; addresses and data are zero outside their phase.
  always_comb begin
    busy        = (state_q != S_IDLE);
    done        = (state_q == S_DONE);
    rd_en       = (state_q == S_READ);
    wr_en       = (state_q == S_WRITE);
    rd_addr     = rd_en ? (srcBase_q + ADDR_W'(row_q)) : '0;
    wr_addr     = wr_en ? (dstBase_q + ADDR_W'(row_q)) : '0;
    wr_data     = wr_en ? conv_result : '0;
    conv_data   = convData_q;
    conv_weight = weight_q;
  end

endmodule

// File: tb/tb_conv_row_sequencer.sv
// tb_conv_row_sequencer
// Drives conv_row_sequencer with a source row memory, a behavioural
// convolution array and a destination responder with optional stalls.
// Expected addresses, windows, results and cycle numbers come from a
// job-level model built from row indices and plain arithmetic.

module tb_conv_row_sequencer;

  localparam int CONV_LAT = 2;
  localparam int ADDR_W   = 10;
  localparam int ROW_W    = 10;
  localparam int PERIOD   = CONV_LAT + 3;

  typedef struct {
    int          src;
    int          dst;
    int          n;
    logic [23:0] weight;
    bit          pad;
    int          stallRow;
    int          stall;
    bit          midStart;
    int          expDone;
  } jobT;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [ROW_W-1:0]  num_rows = '0;
  logic [ADDR_W-1:0] src_base = '0;
  logic [ADDR_W-1:0] dst_base = '0;
  logic [23:0]       weight_in = '0;
  logic              pad_mode = 1'b0;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [1023:0]     rd_data = '0;
  logic [1039:0]     conv_data;
  logic [23:0]       conv_weight;
  logic [1023:0]     conv_result = '0;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [1023:0]     wr_data;
  logic              wr_ready = 1'b1;

  logic [1023:0] srcMem [1024];
  logic [1023:0] convStage = '0;

  int nChecks = 0;
  int nFails  = 0;
  int cyc     = 0;

  int            jobSrc, jobDst, expN, jobStartCyc;
  logic [23:0]   jobWeight;
  logic [1039:0] expWin [8];
  logic [1023:0] expRes [8];
  int            readsSeen, writesSeen, donesSeen, doneCyc;
  int            rowReadCyc, lastAcceptCyc;
  int            stallRow = -1;
  int            stallCycles = 0;
  int            stallLeft = 0;
  logic [1023:0] lastWrData = '0;

  jobT jobs [6];

  conv_row_sequencer #(.CONV_LAT(CONV_LAT), .ADDR_W(ADDR_W), .ROW_W(ROW_W)) dut (
    .clk(clk), .reset(reset), .start(start), .num_rows(num_rows),
    .src_base(src_base), .dst_base(dst_base), .weight_in(weight_in),
    .pad_mode(pad_mode), .busy(busy), .done(done), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(rd_data), .conv_data(conv_data),
    .conv_weight(conv_weight), .conv_result(conv_result), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle counter: value seen between edges names the current cycle.
  always @(posedge clk) cyc <= cyc + 1;

  // Source memory returns the addressed row one cycle after rd_en.
  always @(posedge clk) if (rd_en) rd_data <= srcMem[rd_addr];

  // Behavioural convolution array with a CONV_LAT=2 pipeline.
  always @(posedge clk) begin
    convStage   <= convolve(conv_data, conv_weight);
    conv_result <= convStage;
  end

  function automatic logic [1039:0] makeWindow(input logic [1023:0] row, input bit pad);
    logic [7:0]    b [130];
    logic [1039:0] w;
    for (int p = 0; p < 128; p++) b[p+1] = row[8*p +: 8];
    b[0]   = pad ? b[1]   : 8'h00;
    b[129] = pad ? b[128] : 8'h00;
    for (int i = 0; i < 130; i++) w[8*i +: 8] = b[i];
    return w;
  endfunction

  function automatic logic [1023:0] convolve(input logic [1039:0] win, input logic [23:0] w);
    logic [1023:0] r;
    int acc;
    for (int p = 0; p < 128; p++) begin
      acc = int'(win[8*p +: 8]) * int'(w[7:0]) + int'(win[8*(p+1) +: 8]) * int'(w[15:8])
          + int'(win[8*(p+2) +: 8]) * int'(w[23:16]);
      r[8*p +: 8] = 8'((acc >> 4) & 255);
    end
    return r;
  endfunction

  task automatic checkInt(input string name, input longint act, input longint exp);
    nChecks++;
    if (act != exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic checkWide(input string name, input logic [1039:0] act, input logic [1039:0] exp);
    bit shown;
    nChecks++;
    if (act !== exp) begin
      nFails++;
      shown = 0;
      for (int i = 0; i < 130; i++) begin
        if (!shown && act[8*i +: 8] !== exp[8*i +: 8]) begin
          $display("[TB] FAIL %s: byte %0d got %h expected %h (cycle %0d)", name, i, act[8*i +: 8], exp[8*i +: 8], cyc);
          shown = 1;
        end
      end
    end
  endtask

  // Destination responder and scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (wr_en && stallLeft > 0 && writesSeen == stallRow) begin
      wr_ready = 1'b0;
      stallLeft--;
    end else begin
      wr_ready = 1'b1;
    end
    if (rd_en) begin
      checkInt("rd_addr", rd_addr, (jobSrc + readsSeen) % 1024);
      checkInt("rd_cycle", cyc, (readsSeen == 0) ? jobStartCyc + 1 : lastAcceptCyc + 1);
      rowReadCyc = cyc;
      readsSeen++;
    end
    if (wr_en) begin
      if (writesSeen < expN) begin
        checkInt("wr_addr", wr_addr, (jobDst + writesSeen) % 1024);
        checkWide("conv_data", conv_data, expWin[writesSeen]);
        checkWide("wr_data", {16'h0, wr_data}, {16'h0, expRes[writesSeen]});
        checkInt("conv_weight", conv_weight, jobWeight);
        if (wr_ready) begin
          checkInt("wr_accept_cycle", cyc,
                   rowReadCyc + 2 + CONV_LAT + ((writesSeen == stallRow) ? stallCycles : 0));
          lastWrData    = wr_data;
          lastAcceptCyc = cyc;
          writesSeen++;
        end
      end else begin
        checkInt("extra_write", writesSeen, expN - 1);
        if (wr_ready) writesSeen++;
      end
    end
    if (done) begin
      donesSeen++;
      doneCyc = cyc;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic scrambleConfig();
    num_rows  = ROW_W'($urandom_range(1, 5));
    src_base  = ADDR_W'($urandom);
    dst_base  = ADDR_W'($urandom);
    weight_in = 24'($urandom);
    pad_mode  = 1'($urandom);
  endtask

  task automatic prepJob(input jobT j);
    jobSrc      = j.src;
    jobDst      = j.dst;
    expN        = j.n;
    jobWeight   = j.weight;
    stallRow    = j.stallRow;
    stallCycles = j.stall;
    stallLeft   = j.stall;
    readsSeen   = 0;
    writesSeen  = 0;
    donesSeen   = 0;
    doneCyc     = -1;
    for (int r = 0; r < j.n; r++) begin
      expWin[r] = makeWindow(srcMem[(j.src + r) % 1024], j.pad);
      expRes[r] = convolve(expWin[r], j.weight);
    end
  endtask

  task automatic launch(input jobT j);
    start       = 1'b1;
    num_rows    = ROW_W'(j.n);
    src_base    = ADDR_W'(j.src);
    dst_base    = ADDR_W'(j.dst);
    weight_in   = j.weight;
    pad_mode    = j.pad;
    jobStartCyc = cyc;
    tick();
    start = 1'b0;
    scrambleConfig();
  endtask

  task automatic applyStimulus(input jobT j);
    prepJob(j);
    launch(j);
    while (donesSeen == 0 && cyc < jobStartCyc + 200) begin
      start = j.midStart && (cyc == jobStartCyc + 3);
      if (start) scrambleConfig();
      tick();
    end
    start = 1'b0;
    if (j.midStart && j.n == 0 && donesSeen != 0) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
  endtask

  task automatic checkOutput(input jobT j);
    checkInt("done_cycle", (doneCyc < 0) ? -1 : doneCyc - jobStartCyc, j.expDone);
    repeat (3) tick();
    checkInt("busy_after", busy, 0);
    checkInt("reads", readsSeen, j.n);
    checkInt("writes", writesSeen, j.n);
    checkInt("done_pulses", donesSeen, 1);
  endtask

  task automatic checkAllZero(input string tag);
    checkInt({tag, "_busy"}, busy, 0);
    checkInt({tag, "_done"}, done, 0);
    checkInt({tag, "_rd_en"}, rd_en, 0);
    checkInt({tag, "_wr_en"}, wr_en, 0);
    checkInt({tag, "_rd_addr"}, rd_addr, 0);
    checkInt({tag, "_wr_addr"}, wr_addr, 0);
    checkInt({tag, "_conv_weight"}, conv_weight, 0);
    checkWide({tag, "_conv_data"}, conv_data, '0);
    checkWide({tag, "_wr_data"}, {16'h0, wr_data}, '0);
  endtask

  initial begin
    jobT rj;
    jobT rnd;

    for (int r = 0; r < 1024; r++)
      for (int k = 0; k < 32; k++) srcMem[r][32*k +: 32] = $urandom;
    for (int p = 0; p < 128; p++) srcMem[0][8*p +: 8] = 8'(p + 1);
    for (int r = 10; r < 13; r++) begin
      srcMem[r][7:0]       = 8'h50;
      srcMem[r][1023:1016] = 8'hA0;
    end

    // src, dst, n, weight, pad, stallRow, stall, midStart, expected done cycle
    jobs[0] = '{0,    100,  1, 24'h010201, 1'b0, -1, 0, 1'b0, 6};
    jobs[1] = '{10,   400,  3, 24'h020402, 1'b1, -1, 0, 1'b0, 16};
    jobs[2] = '{20,   300,  2, 24'h030303, 1'b0,  1, 3, 1'b0, 14};
    jobs[3] = '{5,    6,    0, 24'h112233, 1'b1, -1, 0, 1'b1, 1};
    jobs[4] = '{30,   500,  2, 24'h010101, 1'b1, -1, 0, 1'b1, 11};
    jobs[5] = '{1023, 1023, 2, 24'h040804, 1'b0, -1, 0, 1'b0, 11};

    repeat (3) tick();
    checkAllZero("reset");
    reset = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      applyStimulus(jobs[i]);
      checkOutput(jobs[i]);
      if (i == 0) checkInt("t1_pixel0", lastWrData[7:0], 0);
    end

    // Reset during row 1 WAIT of a 4-row job.
    rj = '{40, 200, 4, 24'h030502, 1'b1, -1, 0, 1'b0, 21};
    prepJob(rj);
    launch(rj);
    while (cyc < jobStartCyc + 8) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkAllZero("midreset");
    repeat (20) tick();
    checkInt("midreset_reads", readsSeen, 2);
    checkInt("midreset_writes", writesSeen, 1);
    checkInt("midreset_dones", donesSeen, 0);
    applyStimulus(rj);
    checkOutput(rj);

    // Randomised jobs against the job-level model.
    for (int i = 0; i < 6; i++) begin
      rnd.src      = int'($urandom_range(0, 1023));
      rnd.dst      = int'($urandom_range(0, 1023));
      rnd.n        = int'($urandom_range(1, 4));
      rnd.weight   = 24'($urandom);
      rnd.pad      = 1'($urandom);
      rnd.stallRow = int'($urandom_range(0, rnd.n - 1));
      rnd.stall    = int'($urandom_range(0, 3));
      rnd.midStart = 1'($urandom);
      rnd.expDone  = 1 + rnd.n * PERIOD + rnd.stall;
      applyStimulus(rnd);
      checkOutput(rnd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
